// File: rtl/reg_wr_pkg.sv
// Shared types and widths for the register-write sequencer.
package reg_wr_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wr_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_cmd_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// In-order command buffer with registered count/full/empty; push is allowed
// on a full FIFO when a pop happens on the same edge.
module cmd_fifo
  import reg_wr_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  wr_cmd_t          wr_data_i,
  output wr_cmd_t          rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  wr_cmd_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               push_ok;
  logic               pop_ok;

  always_comb begin
    pop_ok   = pop_i && !empty_q;
    push_ok  = push_i && (!full_q || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/reg_write_sequencer.sv
// Buffers (addr, data) commands and replays them as setup/strobe/hold write
// cycles. Define REG_WR_SHADOW_EN to add a readable shadow of the written registers.
module reg_write_sequencer
  import reg_wr_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              write_strobe,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic [LVL_W-1:0]  fifo_level
`ifdef REG_WR_SHADOW_EN
  ,
  input  logic [ADDR_W-1:0] shadow_sel,
  output logic [DATA_W-1:0] shadow_data
`endif
);

  localparam int unsigned MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  wr_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               strobe_q, strobe_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               busy_q, busy_d;
  logic [LVL_W-1:0]   level_d;
  logic               push;
  logic               pop;
  wr_cmd_t            push_cmd;
  wr_cmd_t            head;
  logic               fifo_full;
  logic               fifo_empty;

  assign push_cmd = '{addr: cmd_addr, data: cmd_data};

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .pop_i    (pop),
    .wr_data_i(push_cmd),
    .rd_data_o(head),
    .count_o  (fifo_level),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Phase sequencing: one counter reused across setup, strobe and hold.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_d = strobe_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SETUP;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d  = STROBE;
          cnt_d    = '0;
          strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d  = HOLD;
          cnt_d    = '0;
          strobe_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        strobe_d = 1'b0;
      end
    endcase

    push    = cmd_valid && cmd_ready;
    addr_d  = pop ? head.addr : addr_q;
    data_d  = pop ? head.data : data_q;
    level_d = fifo_level + LVL_W'(push) - LVL_W'(pop);
    busy_d  = (state_d != IDLE) || (level_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
    end
  end

  assign cmd_ready    = !fifo_full;
  assign write_strobe = strobe_q;
  assign address      = addr_q;
  assign data         = data_q;
  assign busy         = busy_q;

`ifdef REG_WR_SHADOW_EN
  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] shadow_q [NREG];

  // Shadow captures the value on the edge the strobe rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
    end else if (state_q == SETUP && state_d == STROBE) begin
      shadow_q[addr_q] <= data_q;
    end
  end

  assign shadow_data = shadow_q[shadow_sel];
`endif

endmodule
